game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for breakout. Sequences attract, serve, play, ball-lost, level-cleared and game-over phases; gates ball motion and paddle control; reloads block state; tracks lives, score and level. Sits between the VGA timing generator (frame pulse), the button inputs, and the ball, paddle and block-state logic.

## Interface

- NUM_LIVES, 3: lives at game start; legal range 1..3.
- SERVE_FRAMES, 60: frames the ball is held on the paddle before launch; at least 1.
- PAUSE_FRAMES, 90: frames spent in LOST and CLEARED; at least 1.
- SCORE_W, 10: score register width.

- clk  in  1  system clock.
- nRst  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; low freezes all state.
- frame_pulse  in  1  one-cycle pulse per VGA frame.
- btn_select  in  1  raw select button, asynchronous to clk.
- ball_lost  in  1  one-cycle pulse; ball passed the bottom edge.
- block_hit  in  1  one-cycle pulse; one block destroyed.
- all_cleared  in  1  level; no blocks remain.
- do_move  out  1  ball may move (PLAY only).
- ball_hold  out  1  ball is parked on the paddle.
- paddle_en  out  1  paddle responds to buttons.
- blocks_reset  out  1  one-cycle pulse; reload the full block state.
- lives  out  2  remaining lives.
- score  out  SCORE_W  blocks destroyed this game.
- level  out  4  current level, starting at 0.
- state  out  3  encoded state for debug: IDLE=0, SERVE=1, PLAY=2, LOST=3, CLEARED=4, OVER=5.

## Operation

- btn_select passes through a 2-FF synchronizer. A registered rising-edge detect produces sel_rise, a one-cycle pulse.
- frm_cnt counts frame_pulse events. It clears on every state change.
- IDLE: on sel_rise, go to SERVE. Same cycle: lives=NUM_LIVES, score=0, level=0, blocks_reset pulses.
- SERVE: when frm_cnt reaches SERVE_FRAMES, go to PLAY. sel_rise in SERVE goes to PLAY immediately (early launch).
- PLAY:
  - all_cleared=1: go to CLEARED.
  - Otherwise, ball_lost with lives>1: decrement lives, go to LOST.
  - Otherwise, ball_lost with lives==1: lives=0, go to OVER.
- LOST: when frm_cnt reaches PAUSE_FRAMES, go to SERVE.
- CLEARED: when frm_cnt reaches PAUSE_FRAMES, go to SERVE. Same cycle: blocks_reset pulses; level increments, saturating at 15.
- OVER: sel_rise goes to IDLE. score, level and lives hold their values for display.
- score increments on block_hit only in PLAY. It saturates at 2^SCORE_W-1.
- Output decode (registered from next state):
  - do_move=1 only in PLAY.
  - ball_hold=1 in all states except PLAY.
  - paddle_en=1 in SERVE and PLAY.
- Priority in PLAY: all_cleared beats ball_lost in the same cycle. A block_hit in that same cycle still scores.
- en=0: state, counters, score, lives and level hold. frame_pulse, ball_lost, block_hit and sel_rise are ignored. do_move=0, and blocks_reset is suppressed. The synchronizer keeps running.
- Illegal state encodings recover to IDLE on the next clock.

## Timing

- Reset values: state=IDLE, do_move=0, ball_hold=1, paddle_en=0, blocks_reset=0, lives=NUM_LIVES, score=0, level=0, frm_cnt=0. The synchronizer and edge registers reset to 0.
- btn_select to sel_rise: 3 clk (2 sync + 1 edge). State change is 1 clk after sel_rise.
- Event inputs (ball_lost, block_hit, frame_pulse) are registered internally. All outputs change on the clock edge after the qualifying input cycle.
- SERVE lasts exactly SERVE_FRAMES frame_pulse events. The transition happens on the clock after the pulse that makes frm_cnt==SERVE_FRAMES.
- blocks_reset is high for exactly 1 clk per new game or level.
- Reset asserted mid-game returns everything to reset values immediately and asynchronously. Release is synchronous to clk.

## Test plan

- Reset, hold btn_select=0 for 10 frames -> state=0, lives=3, score=0, do_move=0, ball_hold=1, blocks_reset never high.
- Press select, then run 60 frame_pulses -> blocks_reset one 1-clk pulse; state=1; then state=2 and do_move=1 after the 60th pulse.
- In PLAY, issue 5 block_hit, then ball_lost -> score=5, lives=2, state=3. After 90 frames: state=1, then state=2 after 60 more.
- Lose three balls -> lives=0, state=5, score held. sel_rise -> state=0. sel_rise again -> lives=3, score=0.
- all_cleared and ball_lost in the same clk with lives=1 -> state=4 and lives stays 1. After 90 frames: level=1 and blocks_reset pulses once.
- Mid-SERVE at frm_cnt=30, drop en for 100 frames -> frm_cnt holds at 30. After en=1, PLAY is reached after exactly 30 more frames.
- With SCORE_W=4, 20 block_hit -> score=15.

Source files
------------

// File: rtl/game_sequencer.sv
// Breakout phase controller: sequences attract/serve/play/lost/cleared/over,
// gates ball and paddle, reloads blocks and keeps lives, score and level.
module game_sequencer #(
    parameter int NUM_LIVES    = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90,
    parameter int SCORE_W      = 10
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic               frame_pulse,
    input  logic               btn_select,
    input  logic               ball_lost,
    input  logic               block_hit,
    input  logic               all_cleared,
    output logic               do_move,
    output logic               ball_hold,
    output logic               paddle_en,
    output logic               blocks_reset,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SERVE   = 3'd1,
        S_PLAY    = 3'd2,
        S_LOST    = 3'd3,
        S_CLEARED = 3'd4,
        S_OVER    = 3'd5
    } state_e;

    localparam int CNT_MAX = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SERVE_CNT  = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] PAUSE_CNT  = CNT_W'(PAUSE_FRAMES);
    localparam logic [1:0]       LIVES_INIT = 2'(NUM_LIVES);

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q, sync3_q, sel_q;
    logic               fp_q, lost_q, hit_q, clr_q;
    logic [CNT_W-1:0]   frm_cnt_q, frm_cnt_d, frm_inc;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         level_q, level_d;
    logic               blocks_reset_q, blocks_reset_d;
    logic               do_move_q, ball_hold_q, paddle_en_q;
    logic               act_sel, act_fp, act_lost, act_hit, act_clr;

    // Synchronizer runs regardless of en; events are captured only while enabled.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            sel_q   <= 1'b0;
            fp_q    <= 1'b0;
            lost_q  <= 1'b0;
            hit_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            sync1_q <= btn_select;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            sel_q   <= sync2_q & ~sync3_q;
            fp_q    <= frame_pulse & en;
            lost_q  <= ball_lost & en;
            hit_q   <= block_hit & en;
            clr_q   <= all_cleared & en;
        end
    end

    assign act_sel  = en & sel_q;
    assign act_fp   = en & fp_q;
    assign act_lost = en & lost_q;
    assign act_hit  = en & hit_q;
    assign act_clr  = en & clr_q;
    assign frm_inc  = frm_cnt_q + CNT_W'(act_fp & ~(&frm_cnt_q));

    always_comb begin
        state_d        = state_q;
        frm_cnt_d      = frm_inc;
        lives_d        = lives_q;
        score_d        = score_q;
        level_d        = level_q;
        blocks_reset_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act_sel) begin
                    state_d        = S_SERVE;
                    lives_d        = LIVES_INIT;
                    score_d        = '0;
                    level_d        = '0;
                    blocks_reset_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (act_sel || (frm_inc >= SERVE_CNT)) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (act_hit && (score_q != '1)) score_d = score_q + 1'b1;
                // A cleared field outranks a lost ball in the same cycle.
                if (act_clr) begin
                    state_d = S_CLEARED;
                end else if (act_lost) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = S_LOST;
                    end else begin
                        lives_d = '0;
                        state_d = S_OVER;
                    end
                end
            end
            S_LOST: begin
                if (frm_inc >= PAUSE_CNT) state_d = S_SERVE;
            end
            S_CLEARED: begin
                if (frm_inc >= PAUSE_CNT) begin
                    state_d        = S_SERVE;
                    blocks_reset_d = 1'b1;
                    if (level_q != 4'hF) level_d = level_q + 1'b1;
                end
            end
            S_OVER: begin
                if (act_sel) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) frm_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= S_IDLE;
            frm_cnt_q      <= '0;
            lives_q        <= LIVES_INIT;
            score_q        <= '0;
            level_q        <= '0;
            blocks_reset_q <= 1'b0;
            do_move_q      <= 1'b0;
            ball_hold_q    <= 1'b1;
            paddle_en_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            frm_cnt_q      <= frm_cnt_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            level_q        <= level_d;
            blocks_reset_q <= blocks_reset_d;
            do_move_q      <= en & (state_d == S_PLAY);
            ball_hold_q    <= (state_d != S_PLAY);
            paddle_en_q    <= (state_d == S_SERVE) || (state_d == S_PLAY);
        end
    end

    assign do_move      = do_move_q;
    assign ball_hold    = ball_hold_q;
    assign paddle_en    = paddle_en_q;
    assign blocks_reset = blocks_reset_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign level        = level_q;
    assign state        = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: phase-level reference model plus directed game scenarios
// and a randomized run; a second instance checks narrow-score saturation.
module tb_game_sequencer;
    localparam int NL = 3, SF = 60, PF = 90, EXP_W = 27;
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_LOST = 3, P_CLEARED = 4, P_OVER = 5;

    logic clk = 1'b0, nRst = 1'b0, en = 1'b0;
    logic frame_pulse = 1'b0, btn_select = 1'b0, ball_lost = 1'b0, block_hit = 1'b0, all_cleared = 1'b0;
    logic do_move, ball_hold, paddle_en, blocks_reset;
    logic [1:0] lives;
    logic [9:0] score;
    logic [3:0] level;
    logic [2:0] state;
    logic do_move4, ball_hold4, paddle_en4, blocks_reset4;
    logic [1:0] lives4;
    logic [3:0] score4;
    logic [3:0] level4;
    logic [2:0] state4;

    int checks = 0, failures = 0, br_count = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference model: game phase, frames spent in it, and game counters.
    int m_ph, m_frames, m_lives, m_score, m_level;
    bit m_fp, m_lost, m_hit, m_clr;
    bit [3:0] m_hist;

    game_sequencer #(.NUM_LIVES(NL), .SERVE_FRAMES(SF), .PAUSE_FRAMES(PF), .SCORE_W(10)) dut (
        .clk(clk), .nRst(nRst), .en(en), .frame_pulse(frame_pulse), .btn_select(btn_select),
        .ball_lost(ball_lost), .block_hit(block_hit), .all_cleared(all_cleared),
        .do_move(do_move), .ball_hold(ball_hold), .paddle_en(paddle_en), .blocks_reset(blocks_reset),
        .lives(lives), .score(score), .level(level), .state(state));

    game_sequencer #(.NUM_LIVES(NL), .SERVE_FRAMES(SF), .PAUSE_FRAMES(PF), .SCORE_W(4)) dut4 (
        .clk(clk), .nRst(nRst), .en(en), .frame_pulse(frame_pulse), .btn_select(btn_select),
        .ball_lost(ball_lost), .block_hit(block_hit), .all_cleared(all_cleared),
        .do_move(do_move4), .ball_hold(ball_hold4), .paddle_en(paddle_en4), .blocks_reset(blocks_reset4),
        .lives(lives4), .score(score4), .level(level4), .state(state4));

    // Clock
    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    task automatic m_reset();
        m_ph = P_IDLE; m_frames = 0; m_lives = NL; m_score = 0; m_level = 0;
        m_fp = 0; m_lost = 0; m_hit = 0; m_clr = 0; m_hist = '0;
    endtask

    task automatic m_step();
        bit sel, br;
        int nxt, cnt;
        sel = m_hist[2] & ~m_hist[3];
        br  = 0;
        nxt = m_ph;
        if (en) begin
            cnt = m_frames + (m_fp ? 1 : 0);
            case (m_ph)
                P_IDLE: if (sel) begin
                    nxt = P_SERVE; m_lives = NL; m_score = 0; m_level = 0; br = 1;
                end
                P_SERVE: if (sel || cnt >= SF) nxt = P_PLAY;
                P_PLAY: begin
                    if (m_hit) m_score++;
                    if (m_clr) nxt = P_CLEARED;
                    else if (m_lost) begin
                        if (m_lives > 1) begin m_lives--; nxt = P_LOST; end
                        else begin m_lives = 0; nxt = P_OVER; end
                    end
                end
                P_LOST: if (cnt >= PF) nxt = P_SERVE;
                P_CLEARED: if (cnt >= PF) begin
                    nxt = P_SERVE; br = 1; m_level = sat(m_level + 1, 15);
                end
                P_OVER: if (sel) nxt = P_IDLE;
                default: nxt = P_IDLE;
            endcase
            m_frames = (nxt != m_ph) ? 0 : cnt;
        end
        m_ph   = nxt;
        m_hist = {m_hist[2:0], btn_select};
        m_fp   = frame_pulse & en;
        m_lost = ball_lost & en;
        m_hit  = block_hit & en;
        m_clr  = all_cleared & en;
        exp_q.push_back({3'(m_ph), 2'(m_lives), 10'(sat(m_score, 1023)), 4'(m_level),
                         en && (m_ph == P_PLAY), m_ph != P_PLAY,
                         (m_ph == P_SERVE) || (m_ph == P_PLAY), br, 4'(sat(m_score, 15))});
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) begin
                m_reset();
                exp_q.delete();
            end else begin
                m_step();
            end
        end
    end

    // Scoreboard: every cycle after reset release, both instances against the model.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (blocks_reset === 1'b1) br_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cyc_state", state, e[26:24]);
                chk("cyc_lives", lives, e[23:22]);
                chk("cyc_score", score, e[21:12]);
                chk("cyc_level", level, e[11:8]);
                chk("cyc_flags", {do_move, ball_hold, paddle_en, blocks_reset}, e[7:4]);
                chk("cyc4_state", state4, e[26:24]);
                chk("cyc4_lives_level", {lives4, level4}, {e[23:22], e[11:8]});
                chk("cyc4_flags", {do_move4, ball_hold4, paddle_en4, blocks_reset4}, e[7:4]);
                chk("cyc4_score", score4, e[3:0]);
            end
        end
    end

    // Driver tasks (inputs change just after the falling edge)
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_pulse = 1'b1; cyc(1);
            frame_pulse = 1'b0; cyc($urandom_range(2, 4));
        end
    endtask

    task automatic press();
        btn_select = 1'b1; cyc(6);
        btn_select = 1'b0; cyc(6);
    endtask

    task automatic hit();
        block_hit = 1'b1; cyc(1);
        block_hit = 1'b0; cyc(2);
    endtask

    task automatic lose();
        ball_lost = 1'b1; cyc(1);
        ball_lost = 1'b0; cyc(2);
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
        finish_run();
    end

    initial begin
        int br0;
        nRst = 1'b0;
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_level", level, 0);
        chk("rst_flags", {do_move, ball_hold, paddle_en, blocks_reset}, 4'b0100);
        en = 1'b1; nRst = 1'b1;
        cyc(1);
        chk("rel_state", state, 0);

        frames(10);
        chk("attract_state", state, 0);
        chk("attract_lives", lives, 3);
        chk("attract_domove", do_move, 0);
        chk("attract_noreset", br_count, 0);

        press();
        chk("start_state", state, 1);
        chk("start_paddle", paddle_en, 1);
        chk("start_br", br_count, 1);
        frames(59);
        chk("serve59_state", state, 1);
        frames(1);
        chk("serve60_state", state, 2);
        chk("serve60_domove", do_move, 1);
        chk("serve60_hold", ball_hold, 0);

        repeat (5) hit();
        lose();
        chk("lost_score", score, 5);
        chk("lost_lives", lives, 2);
        chk("lost_state", state, 3);
        frames(90);
        chk("pause_state", state, 1);
        frames(60);
        chk("replay_state", state, 2);

        lose();
        chk("lost2_lives", lives, 1);
        frames(90);
        press();
        chk("early_launch", state, 2);
        lose();
        chk("over_state", state, 5);
        chk("over_lives", lives, 0);
        chk("over_score", score, 5);
        press();
        chk("idle_state", state, 0);
        chk("idle_score_held", score, 5);
        press();
        chk("new_state", state, 1);
        chk("new_lives", lives, 3);
        chk("new_score", score, 0);
        chk("new_br", br_count, 2);

        press();
        lose(); frames(90); press();
        lose(); frames(90); press();
        chk("last_life_state", state, 2);
        chk("last_life_lives", lives, 1);
        all_cleared = 1'b1; ball_lost = 1'b1; block_hit = 1'b1;
        cyc(1);
        ball_lost = 1'b0; block_hit = 1'b0;
        cyc(3);
        all_cleared = 1'b0;
        chk("clear_state", state, 4);
        chk("clear_lives", lives, 1);
        chk("clear_score", score, 1);
        br0 = br_count;
        frames(89);
        chk("clear89_state", state, 4);
        frames(1);
        chk("clear_done_state", state, 1);
        chk("clear_level", level, 1);
        chk("clear_br_once", br_count, br0 + 1);

        frames(30);
        en = 1'b0;
        cyc(2);
        frames(100);
        press();
        hit();
        chk("frozen_state", state, 1);
        chk("frozen_domove", do_move, 0);
        en = 1'b1;
        cyc(2);
        frames(29);
        chk("resume29_state", state, 1);
        frames(1);
        chk("resume30_state", state, 2);

        repeat (20) hit();
        chk("sat_score10", score, 21);
        chk("sat_score4", score4, 15);

        cyc(1);
        #2 nRst = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_lives", lives, 3);
        chk("async_score", score, 0);
        chk("async_level", level, 0);
        chk("async_flags", {do_move, ball_hold, paddle_en, blocks_reset}, 4'b0100);
        cyc(2);
        nRst = 1'b1;
        cyc(1);

        for (int i = 0; i < 3000; i++) begin
            frame_pulse = ($urandom_range(0, 3) == 0);
            block_hit   = ($urandom_range(0, 5) == 0);
            ball_lost   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0) all_cleared = ~all_cleared;
            if ($urandom_range(0, 24) == 0) btn_select = ~btn_select;
            en = ($urandom_range(0, 29) != 0);
            cyc(1);
        end
        frame_pulse = 1'b0; block_hit = 1'b0; ball_lost = 1'b0; en = 1'b1;
        cyc(4);
        finish_run();
    end
endmodule
